// File: rtl/chan_readout_arb.sv
// chan_readout_arb: round-robin readout of self-describing channel blocks
// into the event-builder FIFO, with a fixed 2-cycle ack-to-write latency.

module chan_readout_arb #(
    parameter int NCH = 16,
    parameter int GW  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [NCH-1:0]    req,
    output logic [NCH-1:0]    ack,
    input  logic [NCH*16-1:0] din,
    input  logic              afull,
    output logic [15:0]       odata,
    output logic              owr,
    output logic              busy,
    output logic [GW-1:0]     gnt,
    output logic [15:0]       blkcnt,
    output logic [7:0]        errcnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_HEAD,
        S_DATA,
        S_DRAIN,
        S_GAP
    } state_t;

    state_t      state;
    state_t      state_n;
    logic        phase;
    logic        phase_n;
    logic [8:0]  rem;
    logic        blk_ok;
    logic        ack_d1;
    logic        disc_d1;

    logic        ack_en;
    logic        grant;
    logic        good_hdr;
    logic        bad_hdr;
    logic        dec_rem;
    logic        blk_done;

    logic        pick_found;
    logic [GW-1:0] pick_idx;
    logic [GW-1:0] scan_idx;

    logic [15:0] chan_word [NCH];
    logic [15:0] cur;

    for (genvar k = 0; k < NCH; k++) begin : g_word
        assign chan_word[k] = din[16*k +: 16];
    end

    assign cur  = chan_word[gnt];
    assign busy = (state != S_IDLE);

    // First requester strictly after the last grant, wrapping at NCH-1
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = gnt;
        scan_idx   = gnt;
        for (int i = 0; i < NCH; i++) begin
            if (scan_idx == GW'(NCH - 1))
                scan_idx = '0;
            else
                scan_idx = scan_idx + 1'b1;
            if (!pick_found && req[scan_idx]) begin
                pick_found = 1'b1;
                pick_idx   = scan_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            phase <= 1'b0;
        end else begin
            state <= state_n;
            phase <= phase_n;
        end
    end

    always_comb begin
        state_n  = state;
        phase_n  = 1'b0;
        ack_en   = 1'b0;
        grant    = 1'b0;
        good_hdr = 1'b0;
        bad_hdr  = 1'b0;
        dec_rem  = 1'b0;
        blk_done = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (enable && pick_found) begin
                    grant   = 1'b1;
                    state_n = S_SETTLE;
                end
            end
            S_SETTLE: begin
                state_n = S_HEAD;
            end
            S_HEAD: begin
                // A bad header is consumed even under afull: it never writes
                if (!cur[15]) begin
                    ack_en  = 1'b1;
                    bad_hdr = 1'b1;
                    state_n = S_DRAIN;
                end else if (!afull) begin
                    ack_en   = 1'b1;
                    good_hdr = 1'b1;
                    if (cur[8:0] == 9'd0)
                        state_n = S_DRAIN;
                    else
                        state_n = S_DATA;
                end
            end
            S_DATA: begin
                if (!afull) begin
                    ack_en  = 1'b1;
                    dec_rem = 1'b1;
                    if (rem == 9'd1)
                        state_n = S_DRAIN;
                end
            end
            S_DRAIN: begin
                phase_n = ~phase;
                if (phase) begin
                    blk_done = blk_ok;
                    state_n  = S_GAP;
                end
            end
            S_GAP: begin
                phase_n = ~phase;
                if (phase)
                    state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_comb begin
        ack = '0;
        if (ack_en)
            ack[gnt] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gnt     <= GW'(NCH - 1);
            rem     <= '0;
            blk_ok  <= 1'b0;
            ack_d1  <= 1'b0;
            disc_d1 <= 1'b0;
            owr     <= 1'b0;
            odata   <= '0;
            blkcnt  <= '0;
            errcnt  <= '0;
        end else begin
            if (grant)
                gnt <= pick_idx;
            if (good_hdr)
                rem <= cur[8:0];
            else if (dec_rem)
                rem <= rem - 9'd1;
            if (good_hdr)
                blk_ok <= 1'b1;
            else if (bad_hdr)
                blk_ok <= 1'b0;
            // The acked word shows on din one cycle later; capture it then
            ack_d1  <= ack_en;
            disc_d1 <= bad_hdr;
            owr     <= ack_d1 && !disc_d1;
            if (ack_d1 && !disc_d1)
                odata <= cur;
            if (blk_done)
                blkcnt <= blkcnt + 16'd1;
            if (bad_hdr && errcnt != 8'hFF)
                errcnt <= errcnt + 8'd1;
        end
    end

    a_ack_onehot : assert property (
        @(posedge clk) disable iff (reset) $onehot0(ack));

    a_ack_state : assert property (
        @(posedge clk) disable iff (reset)
        (ack != '0) |-> (state inside {S_HEAD, S_DATA}));

endmodule

// File: tb/tb_chan_readout_arb.sv
// tb_chan_readout_arb: channel-source model, round-robin block
// reference model and write-latency scoreboard for chan_readout_arb.

module tb_chan_readout_arb;

    localparam int NCH   = 16;
    localparam int GW    = 4;
    localparam int LIMIT = 20000;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              enable = 1'b0;
    logic [NCH-1:0]    req = '0;
    logic [NCH-1:0]    ack;
    logic [NCH*16-1:0] din = '0;
    logic              afull = 1'b0;
    logic [15:0]       odata;
    logic              owr;
    logic              busy;
    logic [GW-1:0]     gnt;
    logic [15:0]       blkcnt;
    logic [7:0]        errcnt;

    chan_readout_arb #(.NCH(NCH), .GW(GW)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .req(req), .ack(ack), .din(din), .afull(afull),
        .odata(odata), .owr(owr), .busy(busy), .gnt(gnt),
        .blkcnt(blkcnt), .errcnt(errcnt)
    );

    always #4 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    logic [15:0] chq   [NCH][$];
    bit          chbad [NCH][$];
    logic [15:0] exp_stream[$];
    int          mgnt = NCH - 1;
    int          exp_blk = 0;
    int          exp_err = 0;
    int          tot_ack = 0;
    int          owrcnt = 0;
    int          ackcnt [NCH];
    bit          p1v = 1'b0;
    bit          p2v = 1'b0;
    logic [15:0] p1w = '0;
    logic [15:0] p2w = '0;
    bit          afull_force = 1'b0;
    bit          afull_rnd = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Channel source: registered din, pointer advances on ack
    always @(posedge clk) begin
        if (reset) begin
            p1v = 1'b0;
            p2v = 1'b0;
            din <= '0;
            req <= '0;
        end else begin
            p2v = p1v;
            p2w = p1w;
            p1v = 1'b0;
            for (int k = 0; k < NCH; k++) begin
                if (chq[k].size() > 0)
                    din[k*16 +: 16] <= chq[k][0];
                else
                    din[k*16 +: 16] <= 16'h0000;
                if (ack[k]) begin
                    chk("ack_nonempty", 32'(chq[k].size() > 0), 32'd1);
                    if (chq[k].size() > 0) begin
                        p1w = chq[k].pop_front();
                        p1v = !chbad[k].pop_front();
                        tot_ack++;
                        ackcnt[k]++;
                    end
                end
                req[k] <= (chq[k].size() > 0);
            end
        end
    end

    always @(posedge clk) begin
        #2;
        afull = afull_force | (afull_rnd & ($urandom_range(0, 2) == 0));
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("owr_latency", 32'(owr), 32'(p2v));
            if (owr) begin
                owrcnt++;
                chk("owr_word", 32'(odata), 32'(p2w));
                chk("stream_left", 32'(exp_stream.size() > 0), 32'd1);
                if (exp_stream.size() > 0)
                    chk("stream_order", 32'(odata),
                        32'(exp_stream.pop_front()));
            end
            if (ack != '0)
                chk("ack_onehot", 32'($countones(ack)), 32'd1);
        end
    end

    function automatic bit all_empty();
        bit e;
        e = 1'b1;
        for (int k = 0; k < NCH; k++)
            if (chq[k].size() > 0) e = 1'b0;
        return e;
    endfunction

    // Block-level reference: serve queued blocks in round-robin order
    task automatic model_run();
        logic [15:0] mq [NCH][$];
        logic [15:0] w;
        int k;
        int c;
        for (int i = 0; i < NCH; i++) mq[i] = chq[i];
        k = 0;
        while (k >= 0) begin
            k = -1;
            for (int i = 1; i <= NCH; i++) begin
                c = (mgnt + i) % NCH;
                if (k < 0 && mq[c].size() > 0) k = c;
            end
            if (k >= 0) begin
                mgnt = k;
                w = mq[k].pop_front();
                if (!w[15]) begin
                    if (exp_err < 255) exp_err++;
                end else begin
                    exp_stream.push_back(w);
                    for (int j = 0; j < int'(w[8:0]); j++)
                        exp_stream.push_back(mq[k].pop_front());
                    exp_blk = (exp_blk + 1) % 65536;
                end
            end
        end
    endtask

    task automatic push_w(input int k, input logic [15:0] w, input bit bad);
        chq[k].push_back(w);
        chbad[k].push_back(bad);
    endtask

    task automatic push_blk(input int k, input int len);
        push_w(k, {1'b1, 6'(k), 9'(len)}, 1'b0);
        for (int j = 0; j < len; j++)
            push_w(k, 16'($urandom), 1'b0);
    endtask

    task automatic push_bad(input int k);
        push_w(k, {1'b0, 15'($urandom)}, 1'b1);
    endtask

    task automatic clear_all();
        for (int k = 0; k < NCH; k++) begin
            chq[k].delete();
            chbad[k].delete();
        end
        exp_stream.delete();
        mgnt = NCH - 1;
        exp_blk = 0;
        exp_err = 0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        enable = 1'b0;
        afull_force = 1'b0;
        afull_rnd = 1'b0;
        clear_all();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic run_scen(input string name, input bit rnd_en,
                            input int stall_after);
        int cyc;
        int snap;
        int scnt;
        bit stalled;
        bit done;
        model_run();
        tot_ack = 0;
        owrcnt = 0;
        for (int k = 0; k < NCH; k++) ackcnt[k] = 0;
        cyc = 0;
        snap = 0;
        scnt = 0;
        stalled = 1'b0;
        done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        while (!done && cyc < LIMIT) begin
            enable = rnd_en ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (stall_after > 0 && !stalled && tot_ack == stall_after) begin
                afull_force = 1'b1;
                snap = tot_ack;
                scnt = 5;
                stalled = 1'b1;
            end else if (scnt > 0) begin
                scnt--;
                if (scnt == 0) begin
                    afull_force = 1'b0;
                    chk({name, "_stall_noack"}, 32'(tot_ack), 32'(snap));
                end
            end
            @(posedge clk);
            #1;
            cyc++;
            done = all_empty() && !busy;
        end
        enable = 1'b0;
        afull_force = 1'b0;
        chk({name, "_done"}, 32'(done), 32'd1);
        if (stall_after > 0)
            chk({name, "_stalled"}, 32'(stalled), 32'd1);
        @(negedge clk);
        chk({name, "_flush"}, 32'(exp_stream.size()), 32'd0);
        chk({name, "_blkcnt"}, 32'(blkcnt), 32'(exp_blk));
        chk({name, "_errcnt"}, 32'(errcnt), 32'(exp_err));
        chk({name, "_gnt"}, 32'(gnt), 32'(mgnt));
    endtask

    task automatic load_random();
        for (int k = 0; k < NCH; k++) begin
            if ($urandom_range(0, 9) < 4) begin
                repeat ($urandom_range(1, 2)) begin
                    if ($urandom_range(0, 4) == 0)
                        push_bad(k);
                    else
                        push_blk(k, int'($urandom_range(0, 12)));
                end
            end
        end
    endtask

    initial begin
        int cyc;
        for (int k = 0; k < NCH; k++) ackcnt[k] = 0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_owr", 32'(owr), 32'd0);
        chk("rst_odata", 32'(odata), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_gnt", 32'(gnt), 32'(NCH - 1));
        chk("rst_blkcnt", 32'(blkcnt), 32'd0);
        chk("rst_errcnt", 32'(errcnt), 32'd0);

        @(posedge clk);
        #1;
        push_w(2, 16'h8403, 1'b0);
        push_w(2, 16'h0011, 1'b0);
        push_w(2, 16'h0022, 1'b0);
        push_w(2, 16'h0033, 1'b0);
        run_scen("t1", 1'b0, 0);
        chk("t1_acks", 32'(ackcnt[2]), 32'd4);
        chk("t1_owrs", 32'(owrcnt), 32'd4);
        chk("t1_blk1", 32'(blkcnt), 32'd1);

        do_reset();
        push_w(0, 16'h8001, 1'b0);
        push_w(0, 16'h0A0A, 1'b0);
        push_w(5, 16'h8A01, 1'b0);
        push_w(5, 16'h0B0B, 1'b0);
        run_scen("t2", 1'b0, 0);
        chk("t2_gnt5", 32'(gnt), 32'd5);
        chk("t2_ack0", 32'(ackcnt[0]), 32'd2);
        chk("t2_ack5", 32'(ackcnt[5]), 32'd2);

        @(posedge clk);
        #1;
        push_blk(7, 8);
        run_scen("t3", 1'b0, 4);
        chk("t3_owrs", 32'(owrcnt), 32'd9);

        @(posedge clk);
        #1;
        push_w(1, 16'h0123, 1'b1);
        push_blk(4, 2);
        run_scen("t4", 1'b0, 0);
        chk("t4_ack1", 32'(ackcnt[1]), 32'd1);
        chk("t4_owrs", 32'(owrcnt), 32'd3);
        chk("t4_err1", 32'(errcnt), 32'd1);

        @(posedge clk);
        #1;
        push_w(3, 16'h8600, 1'b0);
        run_scen("t5", 1'b0, 0);
        chk("t5_ack3", 32'(ackcnt[3]), 32'd1);
        chk("t5_owrs", 32'(owrcnt), 32'd1);

        afull_rnd = 1'b1;
        for (int r = 0; r < 4; r++) begin
            @(posedge clk);
            #1;
            load_random();
            run_scen("rnd", 1'b1, 0);
        end
        afull_rnd = 1'b0;

        @(posedge clk);
        #1;
        push_blk(0, 10);
        model_run();
        tot_ack = 0;
        enable = 1'b1;
        cyc = 0;
        while (tot_ack < 3 && cyc < LIMIT) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("t6_reached", 32'(tot_ack), 32'd3);
        chk("t6_busy_pre", 32'(busy), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("t6_ack", 32'(ack), 32'd0);
        chk("t6_owr", 32'(owr), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_gnt", 32'(gnt), 32'(NCH - 1));
        chk("t6_blkcnt", 32'(blkcnt), 32'd0);
        chk("t6_errcnt", 32'(errcnt), 32'd0);
        enable = 1'b0;
        clear_all();
        @(posedge clk);
        #1;
        reset = 1'b0;

        afull_rnd = 1'b1;
        @(posedge clk);
        #1;
        load_random();
        run_scen("post", 1'b1, 0);
        afull_rnd = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule
